// File: rtl/emu_pkg.sv
// rtl/emu_pkg.sv - shared widths, FSM state type and byte-count helper for the emulation transactor
package emu_pkg;

  localparam int EMU_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } emu_state_e;

  function automatic int bytes_for(input int width);
    return (width + EMU_DATA_W - 1) / EMU_DATA_W;
  endfunction

endpackage

// File: rtl/emu_transactor_if.sv
// rtl/emu_transactor_if.sv - 8-bit host bus between the emulator host and the transactor
interface emu_host_if #(
  parameter int ADDR_W = 4
) ();
  import emu_pkg::*;

  logic [EMU_DATA_W-1:0] Din_emu;
  logic [ADDR_W-1:0]     Addr_emu;
  logic                  load_emu;
  logic                  get_emu;
  logic                  step_emu;
  logic [EMU_DATA_W-1:0] Dout_emu;
  logic                  busy_emu;

  modport master (
    output Din_emu, Addr_emu, load_emu, get_emu, step_emu,
    input  Dout_emu, busy_emu
  );

  modport slave (
    input  Din_emu, Addr_emu, load_emu, get_emu, step_emu,
    output Dout_emu, busy_emu
  );

endinterface

// File: rtl/emu_transactor_step_ctrl.sv
// rtl/emu_transactor_step_ctrl.sv - run-N-cycles sequencer: gates the DUT clock enable, then requests one capture
module emu_step_ctrl
  import emu_pkg::*;
(
  input  logic       clk_emu,
  input  logic       rst_n_emu,
  input  logic       start,
  input  logic [7:0] step_cnt,
  output logic       busy_emu,
  output logic       dut_clk_en,
  output logic       capt
);

  emu_state_e state_q, state_d;
  logic [7:0] remaining_q, remaining_d;

  always_ff @(posedge clk_emu or negedge rst_n_emu) begin
    if (!rst_n_emu) begin
      state_q     <= IDLE;
      remaining_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Outputs decode straight from the state flops so the DUT enable cannot glitch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    busy_emu    = 1'b0;
    dut_clk_en  = 1'b0;
    capt        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (step_cnt != 8'd0) begin
            remaining_d = step_cnt;
            state_d     = RUN;
          end else begin
            state_d     = CAPT;
          end
        end
      end
      RUN: begin
        busy_emu    = 1'b1;
        dut_clk_en  = 1'b1;
        remaining_d = remaining_q - 8'd1;
        if (remaining_q == 8'd1) state_d = CAPT;
      end
      CAPT: begin
        busy_emu = 1'b1;
        capt     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/emu_transactor.sv
// rtl/emu_transactor.sv - co-emulation transactor: host byte registers, DUT stimulus/capture packing, stepped runs
module emu_transactor
  import emu_pkg::*;
#(
  parameter int DUT_IN_W  = 4,
  parameter int DUT_OUT_W = 24,
  parameter int NUM_STIM  = bytes_for(DUT_IN_W),
  parameter int NUM_OUT   = bytes_for(DUT_OUT_W),
  parameter int ADDR_W    = 4
) (
  input  logic                 clk_emu,
  input  logic                 rst_n_emu,
  emu_host_if.slave            host,
  output logic [DUT_IN_W-1:0]  dut_in,
  input  logic [DUT_OUT_W-1:0] dut_out,
  output logic                 dut_clk_en
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = '1;
  localparam int STIM_W = EMU_DATA_W * NUM_STIM;
  localparam int OUT_W  = EMU_DATA_W * NUM_OUT;

  logic [EMU_DATA_W-1:0] stim_q [NUM_STIM];
  logic [EMU_DATA_W-1:0] cap_q  [NUM_OUT];
  logic [7:0]            step_cnt_q;
  logic [EMU_DATA_W-1:0] dout_q;

  logic [STIM_W-1:0]     stim_flat;
  logic [OUT_W-1:0]      out_pad;
  logic [EMU_DATA_W-1:0] rd_data;
  logic                  busy;
  logic                  capt;
  logic                  idle;
  logic                  start;

  assign idle  = ~busy;
  assign start = idle & host.step_emu & ~host.load_emu & ~host.get_emu;

  emu_step_ctrl u_step_ctrl (
    .clk_emu    (clk_emu),
    .rst_n_emu  (rst_n_emu),
    .start      (start),
    .step_cnt   (step_cnt_q),
    .busy_emu   (busy),
    .dut_clk_en (dut_clk_en),
    .capt       (capt)
  );

  always_comb begin
    stim_flat = '0;
    for (int k = 0; k < NUM_STIM; k++) stim_flat[k*EMU_DATA_W +: EMU_DATA_W] = stim_q[k];
  end

  // Zero-extends (or trims) the DUT outputs onto the capture byte grid.
  assign out_pad = OUT_W'(dut_out);

  always_comb begin
    rd_data = '0;
    if (host.Addr_emu == CTRL_ADDR) begin
      rd_data = {busy, 7'b0};
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (host.Addr_emu == ADDR_W'(k)) rd_data = cap_q[k];
      end
    end
  end

  always_ff @(posedge clk_emu or negedge rst_n_emu) begin
    if (!rst_n_emu) begin
      for (int k = 0; k < NUM_STIM; k++) stim_q[k] <= '0;
      for (int k = 0; k < NUM_OUT; k++)  cap_q[k]  <= '0;
      step_cnt_q <= 8'd0;
      dout_q     <= '0;
      dut_in     <= '0;
    end else begin
      dout_q <= rd_data;
      if (capt) begin
        for (int k = 0; k < NUM_OUT; k++) cap_q[k] <= out_pad[k*EMU_DATA_W +: EMU_DATA_W];
      end else if (idle) begin
        if (host.load_emu) begin
          dut_in <= DUT_IN_W'(stim_flat);
        end else if (host.get_emu) begin
          for (int k = 0; k < NUM_OUT; k++) cap_q[k] <= out_pad[k*EMU_DATA_W +: EMU_DATA_W];
        end else if (!host.step_emu) begin
          // No write strobe exists: the addressed register takes Din_emu on every quiet idle cycle.
          for (int k = 0; k < NUM_STIM; k++) begin
            if (host.Addr_emu == ADDR_W'(k)) stim_q[k] <= host.Din_emu;
          end
          if (host.Addr_emu == CTRL_ADDR) step_cnt_q <= host.Din_emu;
        end
      end
    end
  end

  assign host.Dout_emu = dout_q;
  assign host.busy_emu = busy;

endmodule

// File: doc/emu_transactor.md
# emu_transactor

Parametrised co-emulation transactor for the poorman's standard emulator. It connects the 8-bit host bus (Din_emu/Dout_emu/Addr_emu, load_emu/get_emu strobes) to a DUT of arbitrary input and output width. It adds a host-triggered run-N-cycles mode: the block gates the DUT clock through an enable for a programmed count, then auto-captures the DUT outputs. It replaces the per-design hand-written emulation wrappers.

## Interface
- DUT_IN_W, default 4: DUT input vector width, 1..120.
- DUT_OUT_W, default 24: DUT output vector width, 1..120.
- NUM_STIM, default ceil(DUT_IN_W/8): stimulus byte registers.
- NUM_OUT, default ceil(DUT_OUT_W/8): capture byte registers.
- ADDR_W, default 4: host address width; 2**ADDR_W-1 must exceed max(NUM_STIM, NUM_OUT).
- clk_emu  in  1  sole clock, rising edge.
- rst_n_emu  in  1  asynchronous, active-low reset.
- Din_emu  in  8  host write data.
- Addr_emu  in  ADDR_W  host byte address.
- load_emu  in  1  transfer stimulus registers to dut_in.
- get_emu  in  1  capture dut_out into output registers.
- step_emu  in  1  start a run of step_cnt DUT cycles.
- Dout_emu  out  8  registered host read data.
- busy_emu  out  1  high while a run or auto-capture is in progress.
- dut_in  out  DUT_IN_W  registered DUT stimulus.
- dut_out  in  DUT_OUT_W  DUT outputs.
- dut_clk_en  out  1  DUT clock enable; DUT advances one cycle per clk_emu edge with it high.

## Operation
- Byte packing: stimulus byte k maps to dut_in[8k+7:8k], byte 0 at the LSBs; bits above DUT_IN_W are dropped. dut_out is zero-padded to 8*NUM_OUT bits, and capture byte k = padded[8k+7:8k].
- CTRL_ADDR = 2**ADDR_W-1.
  - Write: step_cnt <= Din_emu.
  - Read: {busy_emu, 7'b0}.
- Per-cycle priority in IDLE: load_emu > get_emu > step_emu > idle access.
- Idle access, performed every cycle with no strobe:
  - Write Din_emu to stimulus register Addr_emu if Addr_emu < NUM_STIM, or to step_cnt at CTRL_ADDR.
  - Dout_emu <= capture register Addr_emu if Addr_emu < NUM_OUT; status at CTRL_ADDR; else 8'h00.
- load_emu: dut_in <= packed stimulus registers.
- get_emu: capture registers <= dut_out.
- FSM:
  - IDLE, with step_emu and step_cnt != 0: remaining <= step_cnt, go to RUN.
  - IDLE, with step_emu and step_cnt == 0: go to CAPT.
  - RUN: dut_clk_en = 1; remaining decrements each cycle; when remaining == 1, go to CAPT.
  - CAPT: capture registers <= dut_out, go to IDLE.
- busy_emu = (state != IDLE), decoded from state flops, no glitch.
- Inside RUN and CAPT:
  - load_emu, get_emu, step_emu and all host writes are ignored, including step_cnt writes; dut_in stays stable.
  - Reads continue: Dout_emu reflects the capture registers, which still hold pre-run values during RUN, and the status byte.
- step_cnt is not consumed; it is retained for repeated runs.

## Timing
- Reset, asynchronous, clears:
  - Dout_emu=0, busy_emu=0, dut_in=0, dut_clk_en=0.
  - All stimulus and capture registers = 0; step_cnt=0; state=IDLE.
- Reset asserted mid-run:
  - dut_clk_en drops immediately.
  - No capture occurs.
  - The run is not resumed after release.
- Read latency is 1 cycle: Dout_emu holds the value selected by the Addr_emu sampled at the previous edge.
- load_emu at edge t: dut_in is valid after t.
- get_emu at edge t: captures dut_out as sampled at t.
- step_emu sampled at edge t with N = step_cnt:
  - dut_clk_en is high for edges t+1 .. t+N.
  - CAPT samples dut_out at edge t+N+1.
  - busy_emu is high from t to t+N+1, falling at t+N+1.
- step_cnt = 0: busy_emu is high for exactly one cycle; capture at t+1.
- step_cnt = 255: exactly 255 enabled cycles, with no counter wrap.
- Out-of-range address:
  - Write: dropped.
  - Read: 8'h00.

## Structure
- Package emu_pkg:
  - EMU_DATA_W = 8.
  - FSM state enum {IDLE, RUN, CAPT}.
  - Function bytes_for(width).
- Optional sub-module emu_step_ctrl: FSM, remaining counter, dut_clk_en, busy_emu.
- Register file and packing stay in emu_transactor.
- Target size: 150-250 lines.

## Test plan
- Reset mid-run:
  - Stimulus: step_cnt=100, step_emu, assert rst_n_emu low after 10 enabled cycles.
  - Required: dut_clk_en=0 and busy_emu=0 immediately; capture registers 0; Dout_emu reads 8'h00.
- Load path:
  - Stimulus: DUT_IN_W=12; write 0xA5 to addr 0 and 0x3C to addr 1, pulse load_emu.
  - Required: dut_in=12'hCA5.
- Get and read-back:
  - Stimulus: dut_out=24'h123456, pulse get_emu, read addrs 0,1,2,3.
  - Required: Dout_emu=56, 34, 12, 00, each one cycle after its address.
- Step run:
  - Stimulus: step_cnt=5, step_emu, with a counter DUT.
  - Required: exactly 5 dut_clk_en cycles; busy_emu high for 6 cycles; capture register equals 5; CTRL read gives 8'h80 during the run and 8'h00 after.
- Lockout during a run:
  - Stimulus: load_emu, get_emu and a write to addr 0 while busy.
  - Required: dut_in and stimulus register unchanged.
- Zero step:
  - Stimulus: step_cnt=0, step_emu.
  - Required: no dut_clk_en; one-cycle busy_emu; capture updated from dut_out.
